// File: rtl/rdi_clk_gate_ctrl.sv
// RDI mainband clock-gate controller.
// Arbitrates NUM_SRC level wake requests, keeps the mainband clock ungated while
// any requester needs it, and gates it again after a programmable idle hold once
// the link settles into a low-power / reset status. Each requester gets its own
// four-phase wake acknowledge; a wake the LTSM does not complete in WAKE_TMO
// cycles raises a sticky timeout flag.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// GATED     | mainband clock gated, waiting for any wake request
// WAKING    | clock ungated, waiting for the LTSM to confirm wake-up
// ACTIVE    | clock running, acks granted, watching for a gating event
// IDLE_HOLD | gating event seen, counting down the idle hold; a wake aborts

module rdi_clk_gate_ctrl #(
  parameter int NUM_SRC  = 3,
  parameter int IDLE_W   = 8,
  parameter int WAKE_TMO = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_wake_req,
  input  logic [3:0]         i_lp_state_req,
  input  logic [4:0]         i_pl_state_sts,
  input  logic               i_pl_inband_pres,
  input  logic               i_ltsm_in_reset,
  input  logic               i_ltsm_is_waked_up,
  input  logic [IDLE_W-1:0]  i_idle_hold,
  output logic               o_clk_gate_en,
  output logic [NUM_SRC-1:0] o_wake_ack,
  output logic               o_wake_timeout,
  output logic [1:0]         o_state
);

  localparam int TCNT_W = $clog2(WAKE_TMO + 1);
  localparam logic [TCNT_W-1:0] TMO_MAX = TCNT_W'(WAKE_TMO);

  localparam logic [1:0] ST_GATED     = 2'd0;
  localparam logic [1:0] ST_WAKING    = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;
  localparam logic [1:0] ST_IDLE_HOLD = 2'd3;

  localparam logic [4:0] STS_L1        = 5'b00100;
  localparam logic [4:0] STS_L2        = 5'b01000;
  localparam logic [4:0] STS_LINKRESET = 5'b01001;
  localparam logic [4:0] STS_DISABLED  = 5'b01100;

  logic [1:0]         state_q, state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [TCNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic               tmo_q, tmo_d;
  logic               armed_q, armed_d;
  logic               pres_q;
  logic [4:0]         sts_q;
  logic               gate_evt_q;
  logic               clk_gate_en_q;
  logic [NUM_SRC-1:0] wake_ack_q;

  logic any_wake;
  logic reset_cond;
  logic sts_event;
  logic sts_is_lp;

  // Gating-event qualification: armed by inband presence loss, cleared by any wake
  always_comb begin
    any_wake   = |i_wake_req;
    armed_d    = armed_q;
    if (any_wake) begin
      armed_d = 1'b0;
    end else if (pres_q && !i_pl_inband_pres) begin
      armed_d = 1'b1;
    end
    reset_cond = armed_q && (i_pl_state_sts == 5'b00000) && i_ltsm_in_reset &&
                 (i_lp_state_req == 4'b0000);
    sts_is_lp  = (i_pl_state_sts == STS_L1) || (i_pl_state_sts == STS_L2) ||
                 (i_pl_state_sts == STS_LINKRESET) || (i_pl_state_sts == STS_DISABLED);
    sts_event  = (i_pl_state_sts != sts_q) && sts_is_lp;
  end

  // Next-state, idle-hold countdown and wake-timeout tracking
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_d      = tmo_q;
    case (state_q)
      ST_GATED: begin
        if (any_wake) begin
          state_d   = ST_WAKING;
          tmo_cnt_d = '0;
        end
      end
      ST_WAKING: begin
        if (i_ltsm_is_waked_up) begin
          state_d = ST_ACTIVE;
          tmo_d   = 1'b0;
        end else begin
          // No fallback to GATED: the clock stays up and software sees the flag.
          if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
          if (tmo_cnt_d == TMO_MAX) begin
            tmo_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // A gating event coinciding with a wake is dropped, not deferred.
        if (gate_evt_q && !any_wake) begin
          state_d    = ST_IDLE_HOLD;
          idle_cnt_d = i_idle_hold;
        end
      end
      ST_IDLE_HOLD: begin
        if (any_wake) begin
          state_d = ST_ACTIVE;
          tmo_d   = 1'b0;
        end else if (idle_cnt_q == '0) begin
          state_d = ST_GATED;
        end else begin
          idle_cnt_d = idle_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_GATED;
      end
    endcase
  end

  // State, counters, edge-detect history and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_GATED;
      idle_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      tmo_q         <= 1'b0;
      armed_q       <= 1'b0;
      pres_q        <= 1'b0;
      sts_q         <= 5'b00000;
      gate_evt_q    <= 1'b0;
      clk_gate_en_q <= 1'b0;
      wake_ack_q    <= '0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      tmo_q         <= tmo_d;
      armed_q       <= armed_d;
      pres_q        <= i_pl_inband_pres;
      sts_q         <= i_pl_state_sts;
      gate_evt_q    <= reset_cond || sts_event;
      clk_gate_en_q <= (state_q != ST_GATED);
      wake_ack_q    <= i_wake_req & {NUM_SRC{i_ltsm_is_waked_up &&
                       ((state_q == ST_ACTIVE) || (state_q == ST_IDLE_HOLD))}};
    end
  end

  assign o_clk_gate_en  = clk_gate_en_q;
  assign o_wake_ack     = wake_ack_q;
  assign o_wake_timeout = tmo_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_rdi_clk_gate_ctrl.sv
// Testbench for rdi_clk_gate_ctrl: directed walk through the main scenarios,
// then a randomized run, with every cycle compared against a behavioural model.

module tb_rdi_clk_gate_ctrl;

  localparam int NSRC = 3;
  localparam int IDW  = 8;
  localparam int TMO  = 16;

  logic            clk;
  logic            rst_n;
  logic [NSRC-1:0] wake_req;
  logic [3:0]      lp_req;
  logic [4:0]      sts;
  logic            pres;
  logic            in_rst;
  logic            waked;
  logic [IDW-1:0]  idle_hold;
  logic            cg_en;
  logic [NSRC-1:0] ack;
  logic            tmo_flag;
  logic [1:0]      st;

  int n_checks;
  int n_fail;

  // behavioural model: state as 0 gated / 1 waking / 2 active / 3 idle hold
  int m_st;
  int m_cg;
  int m_ack;
  int m_tmo;
  int m_wcycles;
  int m_idle_left;
  int m_armed;
  int m_pres_prev;
  int m_sts_prev;
  int m_gevt;

  rdi_clk_gate_ctrl #(.NUM_SRC(NSRC), .IDLE_W(IDW), .WAKE_TMO(TMO)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_wake_req         (wake_req),
    .i_lp_state_req     (lp_req),
    .i_pl_state_sts     (sts),
    .i_pl_inband_pres   (pres),
    .i_ltsm_in_reset    (in_rst),
    .i_ltsm_is_waked_up (waked),
    .i_idle_hold        (idle_hold),
    .o_clk_gate_en      (cg_en),
    .o_wake_ack         (ack),
    .o_wake_timeout     (tmo_flag),
    .o_state            (st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cg = 0; m_ack = 0; m_tmo = 0; m_wcycles = 0; m_idle_left = 0;
    m_armed = 0; m_pres_prev = 0; m_sts_prev = 0; m_gevt = 0;
  endtask

  task automatic model_step();
    int  any_w;
    int  rc;
    int  se;
    int  new_armed;
    any_w = (wake_req != 0);
    m_ack = (waked && (m_st == 2 || m_st == 3)) ? int'(wake_req) : 0;
    m_cg  = (m_st != 0);
    rc    = m_armed && (sts == 5'd0) && in_rst && (lp_req == 4'd0);
    se    = (int'(sts) != m_sts_prev) &&
            (sts == 5'b00100 || sts == 5'b01000 || sts == 5'b01001 || sts == 5'b01100);
    if (any_w) new_armed = 0;
    else if (m_pres_prev && !pres) new_armed = 1;
    else new_armed = m_armed;
    if (m_st == 0) begin
      if (any_w) begin m_st = 1; m_wcycles = 0; end
    end else if (m_st == 1) begin
      if (waked) begin m_st = 2; m_tmo = 0; end
      else begin
        m_wcycles++;
        if (m_wcycles >= TMO) m_tmo = 1;
      end
    end else if (m_st == 2) begin
      if (m_gevt && !any_w) begin m_st = 3; m_idle_left = int'(idle_hold); end
    end else begin
      if (any_w) begin m_st = 2; m_tmo = 0; end
      else if (m_idle_left == 0) m_st = 0;
      else m_idle_left--;
    end
    m_gevt      = rc || se;
    m_armed     = new_armed;
    m_pres_prev = pres;
    m_sts_prev  = int'(sts);
  endtask

  task automatic check_model();
    chk("state", 32'(st), 32'(m_st));
    chk("clk_gate_en", 32'(cg_en), 32'(m_cg));
    chk("wake_ack", 32'(ack), 32'(m_ack));
    chk("wake_timeout", 32'(tmo_flag), 32'(m_tmo));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // asynchronous reset pulse placed mid-cycle, away from any clock edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_clk_gate_en", 32'(cg_en), 32'd0);
    chk("rst_wake_ack", 32'(ack), 32'd0);
    chk("rst_wake_timeout", 32'(tmo_flag), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; wake_req = '0; lp_req = 4'd0; sts = 5'b00001; pres = 1'b1;
    in_rst = 1'b0; waked = 1'b0; idle_hold = '0;
    model_reset();
    #12 rst_n = 1'b1;
    chk("reset_state", 32'(st), 32'd0);
    chk("reset_clk_gate_en", 32'(cg_en), 32'd0);
    chk("reset_wake_ack", 32'(ack), 32'd0);

    // wake from GATED on source 0, then four-phase ack
    tick_n(4);
    wake_req = 3'b001;
    tick();
    chk("wake_to_waking", 32'(st), 32'd1);
    chk("gate_en_lag", 32'(cg_en), 32'd0);
    tick();
    chk("gate_en_rise", 32'(cg_en), 32'd1);
    waked = 1'b1;
    tick();
    chk("to_active", 32'(st), 32'd2);
    tick();
    chk("ack0_set", 32'(ack), 32'b001);
    wake_req = 3'b000;
    tick();
    chk("ack0_drop", 32'(ack), 32'b000);

    // overlapping acks from sources 1 and 2
    wake_req = 3'b110;
    tick();
    chk("ack_overlap", 32'(ack), 32'b110);
    wake_req = 3'b100;
    tick();
    chk("ack1_drop", 32'(ack), 32'b100);
    wake_req = 3'b000;
    tick();

    // L1 status change gates after idle hold of 4
    idle_hold = 8'd4;
    sts = 5'b00100;
    tick();
    chk("evt_latency", 32'(st), 32'd2);
    tick();
    chk("idle_entry", 32'(st), 32'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle_hold_cnt", 32'(st), 32'd3);
    end
    tick();
    chk("gated_after_hold", 32'(st), 32'd0);
    chk("gate_en_still_on", 32'(cg_en), 32'd1);
    tick();
    chk("gate_en_off", 32'(cg_en), 32'd0);

    // same gating, aborted by source 1 on the 2nd idle-hold cycle
    wake_req = 3'b001;
    tick_n(2);
    chk("rewake_active", 32'(st), 32'd2);
    wake_req = 3'b000;
    sts = 5'b00001;
    tick();
    sts = 5'b00100;
    tick();
    tick();
    chk("abort_idle_entry", 32'(st), 32'd3);
    tick();
    chk("abort_idle_2nd", 32'(st), 32'd3);
    chk("abort_gate_en", 32'(cg_en), 32'd1);
    wake_req = 3'b010;
    tick();
    chk("abort_to_active", 32'(st), 32'd2);
    chk("abort_gate_en_kept", 32'(cg_en), 32'd1);
    wake_req = 3'b000;
    tick();

    // wake timeout with waked_up held low; zero idle hold reaches GATED immediately
    sts = 5'b00001;
    tick();
    sts = 5'b01000;
    idle_hold = 8'd0;
    tick();
    tick();
    chk("zero_hold_entry", 32'(st), 32'd3);
    tick();
    chk("zero_hold_gated", 32'(st), 32'd0);
    tick();
    waked = 1'b0;
    wake_req = 3'b001;
    tick();
    chk("tmo_waking", 32'(st), 32'd1);
    wake_req = 3'b000;
    tick();
    chk("tmo_gate_en", 32'(cg_en), 32'd1);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("tmo_not_yet", 32'(tmo_flag), 32'd0);
    end
    tick();
    chk("tmo_set", 32'(tmo_flag), 32'd1);
    tick_n(3);
    chk("tmo_sticky", 32'(tmo_flag), 32'd1);
    chk("tmo_stay_waking", 32'(st), 32'd1);
    chk("tmo_clock_on", 32'(cg_en), 32'd1);
    waked = 1'b1;
    tick();
    chk("tmo_exit_active", 32'(st), 32'd2);
    chk("tmo_cleared", 32'(tmo_flag), 32'd0);

    // inband presence loss plus LTSM reset gates the clock
    pres = 1'b0; sts = 5'b00000; in_rst = 1'b1; lp_req = 4'd0; idle_hold = 8'd2;
    tick_n(3);
    chk("rc_idle_entry", 32'(st), 32'd3);
    tick_n(2);
    chk("rc_idle_hold", 32'(st), 32'd3);
    tick();
    chk("rc_gated", 32'(st), 32'd0);
    wake_req = 3'b001;
    tick_n(2);
    wake_req = 3'b000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("no_edge_stay_active", 32'(st), 32'd2);
    end

    // reset asserted in the middle of IDLE_HOLD
    pres = 1'b1;
    tick();
    pres = 1'b0;
    idle_hold = 8'd10;
    tick_n(3);
    chk("pre_rst_idle", 32'(st), 32'd3);
    async_reset();

    // randomized run against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(15) == 0) wake_req[b] = ~wake_req[b];
      if ($urandom_range(19) == 0) waked = ~waked;
      if ($urandom_range(7) == 0) pres = ~pres;
      if ($urandom_range(9) == 0) in_rst = ~in_rst;
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(6))
          0: sts = 5'b00000;
          1: sts = 5'b00001;
          2: sts = 5'b00100;
          3: sts = 5'b01000;
          4: sts = 5'b01001;
          5: sts = 5'b01100;
          default: sts = 5'b00011;
        endcase
      end
      lp_req    = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'd0;
      idle_hold = 8'($urandom_range(5));
      if ($urandom_range(499) == 0) async_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
